// File: rtl/shift_seq_pkg.sv
// Shared encodings and default sizes for the multi-cycle shift sequencer.
package shift_seq_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        OP_SRL  = 2'b00,
        OP_SRA  = 2'b01,
        OP_SLL  = 2'b10,
        OP_PASS = 2'b11
    } shift_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } seq_state_e;

endpackage

// File: rtl/shift_step_1bit.sv
// Combinational single-bit shift stage; the sequencer iterates it once per clock.
module shift_step_1bit
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] value,
    input  shift_op_e        op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = value;
        case (op)
            OP_SRL:  result = {1'b0, value[WIDTH-1:1]};
            OP_SRA:  result = {value[WIDTH-1], value[WIDTH-1:1]};
            OP_SLL:  result = {value[WIDTH-2:0], 1'b0};
            default: result = value;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Bit-serial shifter: SRL/SRA/SLL by a saturated amount, one bit per clock.
// Optional macro SHIFT_ZERO_SKIP_EN ends an operation early once the value equals the fill pattern.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] X,
    input  logic [31:0]      Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Z
);

    seq_state_e       state_q, state_d;
    shift_op_e        op_q, op_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_value;
    logic [CNT_W-1:0] load_cnt;
    logic             fill_hit;
    logic             finish;

    shift_step_1bit #(.WIDTH(WIDTH)) u_step (
        .value  (value_q),
        .op     (op_q),
        .result (step_value)
    );

    // Amounts at or above WIDTH saturate rather than wrapping modulo WIDTH.
    always_comb begin
        load_cnt = (Y >= 32'(WIDTH)) ? CNT_W'(WIDTH) : Y[CNT_W-1:0];
        if (shift_op_e'(op) == OP_PASS) begin
            load_cnt = '0;
        end
    end

`ifdef SHIFT_ZERO_SKIP_EN
    // Further shifts cannot change a value that already equals the fill pattern.
    assign fill_hit = (op_q == OP_SRA) ? (value_q == {WIDTH{value_q[WIDTH-1]}})
                                       : (value_q == '0);
`else
    assign fill_hit = 1'b0;
`endif

    assign finish = (cnt_q == '0) || fill_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_SRL;
            value_q <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            value_q <= value_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)  state_d = ST_SHIFT;
            ST_SHIFT: if (finish) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d    = op_q;
        value_d = value_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = shift_op_e'(op);
                    value_d = X;
                    cnt_d   = load_cnt;
                end
            end
            ST_SHIFT: begin
                if (finish) begin
                    z_d    = value_q;
                    done_d = 1'b1;
                end else begin
                    value_d = step_value;
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = done_q;
    assign Z    = z_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed-vector bench for shift_sequencer; expected latencies follow SHIFT_ZERO_SKIP_EN.
module tb_shift_sequencer;

`ifdef SHIFT_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] X;
    logic [31:0] Y;
    logic        busy;
    logic        done;
    logic [31:0] Z;

    int n_checks = 0;
    int n_pass   = 0;

    shift_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .X     (X),
        .Y     (Y),
        .busy  (busy),
        .done  (done),
        .Z     (Z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] z_exp, input int lat_exp);
        int cyc;
        bit seen;
        @(negedge clk);
        start = 1'b1; op = o; X = x; Y = y;
        @(posedge clk);
        #1;
        start = 1'b0; X = '0; Y = '0;
        check({tag, ".busy_on"}, 64'(busy), 64'd1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 80) begin
            @(posedge clk);
            cyc++;
            #1;
            if (done) seen = 1'b1;
        end
        check({tag, ".lat"}, 64'(cyc), 64'(lat_exp));
        check({tag, ".z"}, 64'(Z), 64'(z_exp));
        check({tag, ".busy_off"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, 64'(done), 64'd0);
        check({tag, ".hold"}, 64'(Z), 64'(z_exp));
        $display("%s: op=%0d X=%h Y=%0d -> Z=%h after %0d cycles", tag, o, x, y, Z, cyc);
    endtask

    initial begin
        int cyc;
        int ndone;
        int first_done;

        rst_n = 1'b0; start = 1'b0; op = 2'b00; X = '0; Y = '0;
        #1;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.z", 64'(Z), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("srl_y1",   2'b00, 32'h0000000A, 32'd1,  32'h00000005, 2);
        run_op("srl_y2",   2'b00, 32'h0000000A, 32'd2,  32'h00000002, 3);
        run_op("srl_y7",   2'b00, 32'h0000000A, 32'd7,  32'h00000000, SKIP ? 5 : 8);
        run_op("srl_y35",  2'b00, 32'h0000000A, 32'd35, 32'h00000000, SKIP ? 5 : 33);
        run_op("sra_y35",  2'b01, 32'h80000000, 32'd35, 32'hFFFFFFFF, SKIP ? 32 : 33);
        run_op("sra_y4",   2'b01, 32'h80000000, 32'd4,  32'hF8000000, 5);
        run_op("sra_pos",  2'b01, 32'h7FFFFFFF, 32'd1,  32'h3FFFFFFF, 2);
        run_op("sra_y64",  2'b01, 32'h80000000, 32'd64, 32'hFFFFFFFF, SKIP ? 32 : 33);
        run_op("sll_y31",  2'b10, 32'h00000001, 32'd31, 32'h80000000, 32);
        run_op("sll_y100", 2'b10, 32'h00000001, 32'd100, 32'h00000000, 33);
        run_op("srl_y31",  2'b00, 32'h80000000, 32'd31, 32'h00000001, 32);
        run_op("srl_y0",   2'b00, 32'hDEADBEEF, 32'd0,  32'hDEADBEEF, 1);
        run_op("pass",     2'b11, 32'h00001234, 32'd9,  32'h00001234, 1);

        // Busy start at k+3 and a start on the done edge must both be dropped.
        @(negedge clk);
        start = 1'b1; op = 2'b00; X = 32'h00000400; Y = 32'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0; ndone = 0; first_done = 0;
        while (cyc < 20) begin
            if (cyc == 2 || cyc == 10) begin
                start = 1'b1; op = 2'b10; X = 32'hFFFFFFFF; Y = 32'd1;
            end
            @(posedge clk);
            cyc++;
            #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = cyc;
            end
        end
        check("busy_start.lat", 64'(first_done), 64'd11);
        check("busy_start.ndone", 64'(ndone), 64'd1);
        check("busy_start.z", 64'(Z), 64'h00000001);
        check("busy_start.idle", 64'(busy), 64'd0);
        $display("busy_start: first done after %0d cycles, %0d pulses, Z=%h", first_done, ndone, Z);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; op = 2'b10; X = 32'h00000001; Y = 32'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        check("abort.z", 64'(Z), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        check("abort.quiet", 64'(ndone), 64'd0);
        $display("abort: reset mid-op, Z=%h, activity after release=%0d", Z, ndone);
        run_op("after_rst", 2'b10, 32'h00000001, 32'd20, 32'h00100000, 21);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
